serializer_arbiter: RTL and testbench

Shares one parallel-to-serial converter among NUM_REQ requesters. Each requester presents a word and holds a request. The block picks one requester round-robin, latches its word, and sends a single-cycle start to the serializer. It tracks the serializer's busy signal to completion, then acks the requester. It sits between the packet/command sources and the single serial output lane.

---
 rtl/serializer_arbiter.sv | 124 ++++++++++++
 tb/tb_serializer_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_arbiter.sv
// Round-robin share of one serializer: grant+latch in IDLE, start 1 cycle after req, ack 1 cycle after busy falls.
// Requesters hold req until ack. Define ARB_TIMEOUT_EN to ack with sticky err_o if busy never rises.
module serializer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0] data_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic [NUM_REQ-1:0]           ack_o,
  output logic                         ser_start_o,
  output logic [DATA_SIZE-1:0]         ser_data_o,
  input  logic                         ser_busy_i,
  output logic                         idle_o,
  output logic                         err_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;
  logic                 sel_vld;
  logic [DATA_SIZE-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = data_i[g*DATA_SIZE +: DATA_SIZE];
  end

  // First requester strictly after the last grant, wrapping around.
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!sel_vld && req_i[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt;
`else
  // TIMEOUT_CYCLES has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_o          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      gnt_idx     <= '0;
      grant_o     <= '0;
      ack_o       <= '0;
      ser_start_o <= 1'b0;
      ser_data_o  <= '0;
      idle_o      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_o       <= 1'b0;
`endif
    end else begin
      ack_o       <= '0;
      ser_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            gnt_idx     <= sel_idx;
            grant_o     <= NUM_REQ'(1) << sel_idx;
            ser_data_o  <= words[sel_idx];
            ser_start_o <= 1'b1;
            idle_o      <= 1'b0;
            state       <= START;
          end
        end
        START: begin
          state <= WAIT_BUSY;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (ser_busy_i) begin
            state <= WAIT_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_o <= 1'b1;
            ack_o <= grant_o;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!ser_busy_i) begin
            ack_o <= grant_o;
            state <= DONE;
          end
        end
        DONE: begin
          grant_o <= '0;
          ptr     <= gnt_idx;
          idle_o  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serializer_arbiter.sv
// Randomized scoreboard bench for serializer_arbiter with a simple serializer model.
module tb_serializer_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req_i;
  logic [NR*DW-1:0]   data_i;
  logic [NR-1:0]      grant_o;
  logic [NR-1:0]      ack_o;
  logic               ser_start_o;
  logic [DW-1:0]      ser_data_o;
  logic               ser_busy_i;
  logic               idle_o;
  logic               err_o;

  logic [DW-1:0]      words [NR];

  for (genvar g = 0; g < NR; g++) begin : g_data
    assign data_i[g*DW +: DW] = words[g];
  end

  serializer_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .grant_o(grant_o),
    .ack_o(ack_o), .ser_start_o(ser_start_o), .ser_data_o(ser_data_o),
    .ser_busy_i(ser_busy_i), .idle_o(idle_o), .err_o(err_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   m_ptr   = NR - 1;
  bit   never   = 0;
  bit   glitch  = 0;
  int   ser_len = 4;
  bit   err_exp = 0;

  // Reference: a fixed request set is served in cyclic order starting after the last grant.
  task automatic issue(input logic [NR-1:0] set);
    int last;
    last = m_ptr;
    for (int i = 1; i <= NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (set[k]) begin
        exp_t e;
        e.idx = k;
        e.dat = words[k];
        exp_q.push_back(e);
        last = k;
      end
    end
    m_ptr = last;
  endtask

  // Serializer model: busy rises 1..3 cycles after start and stays for ser_len cycles.
  initial begin
    int dly;
    int len;
    bit gl;
    ser_busy_i = 0;
    dly = -1;
    len = 0;
    gl  = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        ser_busy_i = 0; dly = -1; len = 0; gl = 0;
      end else if (gl) begin
        ser_busy_i = 0; gl = 0;
      end else if (ser_start_o) begin
        if (!never) dly = $urandom_range(0, 2);
      end else if (dly > 0) begin
        dly--;
      end else if (dly == 0) begin
        ser_busy_i = 1; len = ser_len; dly = -1;
      end else if (len > 0) begin
        len--;
        if (len == 0) ser_busy_i = 0;
      end else if (glitch) begin
        ser_busy_i = 1; gl = 1; glitch = 0;
      end
    end
  end

  // Monitor: pops an expectation on every start pulse and checks acks against it.
  initial begin
    int          cur;
    bit          cur_vld;
    logic [DW-1:0] cur_dat;
    int          gap;
    bit          b1, b2;
    int          cyc, start_cyc;
    logic [NR-1:0] oh;
    cur = 0; cur_vld = 0; cur_dat = '0; gap = 100; b1 = 0; b2 = 0; cyc = 0; start_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cur_vld = 0;
        gap     = 100;
      end else begin
        if (ser_start_o) begin
          chk("start_gap_ge2", 32'(gap >= 2), 1);
          gap = 0;
          start_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("start_unexpected", 32'(ser_start_o), 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            chk("grant", 32'(grant_o), 32'(oh));
            chk("ser_data", 32'(ser_data_o), 32'(e.dat));
            cur = e.idx; cur_dat = e.dat; cur_vld = 1;
          end
        end else begin
          gap++;
          if (cur_vld) chk("data_hold", 32'(ser_data_o), 32'(cur_dat));
        end
        if (ack_o != 0) begin
          oh = '0;
          if (cur_vld) oh[cur] = 1'b1;
          chk("ack_who", 32'(ack_o), 32'(oh));
          if (never) chk("tmo_ack_within_6", 32'(cyc - start_cyc <= 6), 1);
          else chk("ack_after_busy_fall", 32'({b2, b1}), 32'(2'b10));
          cur_vld = 0;
        end
      end
      b2 = b1;
      b1 = ser_busy_i;
    end
  end

  task automatic run_batch(input logic [NR-1:0] set, input logic [NR-1:0] scr, input bit lat);
    logic [NR-1:0] pend;
    int n;
    issue(set);
    pend  = set;
    req_i = set;
    n     = 0;
    while (pend != 0 && n < 60 * NR) begin
      @(posedge clk); #1;
      n++;
      if (lat && n == 1) chk("start_latency", 32'(ser_start_o), 1);
      for (int k = 0; k < NR; k++) begin
        if (ack_o[k]) begin
          pend[k]  = 1'b0;
          req_i[k] = 1'b0;
        end
        if (grant_o[k] && scr[k]) begin
          words[k] = 8'hFF;
          req_i[k] = 1'b0;
          scr[k]   = 1'b0;
        end
      end
    end
    chk("batch_complete", 32'(pend), 0);
    req_i = '0;
    @(posedge clk); #1;
    chk("idle_after", 32'(idle_o), 1);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("err", 32'(err_o), 32'(err_exp));
  endtask

  initial begin
    int n;
    rst   = 1;
    req_i = '0;
    for (int k = 0; k < NR; k++) words[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_start", 32'(ser_start_o), 0);
    chk("rst_data", 32'(ser_data_o), 0);
    chk("rst_idle", 32'(idle_o), 1);
    chk("rst_err", 32'(err_o), 0);

    // All requesting: 0,1,2,3 then requester 0 again.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    run_batch(4'b1111, 4'b0000, 1'b0);
    words[0] = 8'hA5;
    ser_len  = 9;
    run_batch(4'b0001, 4'b0000, 1'b1);

    // Wrap: last grant 3, then 1001 serves 0 before 3.
    ser_len = 3;
    run_batch(4'b1000, 4'b0000, 1'b0);
    run_batch(4'b1001, 4'b0000, 1'b0);

    // Data/request changes after grant are ignored.
    words[2] = 8'h3C;
    run_batch(4'b0100, 4'b0100, 1'b0);

    // Busy glitch while idle must not start anything.
    glitch = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("glitch_idle", 32'(idle_o), 1);
    end

    for (int it = 0; it < 25; it++) begin
      logic [NR-1:0] set;
      for (int k = 0; k < NR; k++) words[k] = DW'($urandom);
      ser_len = $urandom_range(1, 6);
      set     = NR'($urandom_range(1, (1 << NR) - 1));
      run_batch(set, NR'($urandom) & set, 1'b0);
    end

    // Reset in WAIT_DONE aborts without ack; pointer returns to NR-1.
    words[1] = 8'h5A;
    ser_len  = 6;
    issue(4'b0010);
    req_i = 4'b0010;
    n = 0;
    while (!ser_busy_i && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_rise", 32'(ser_busy_i), 1);
    @(posedge clk); #1;
    rst   = 1;
    req_i = '0;
    @(posedge clk); #1;
    chk("mid_rst_grant", 32'(grant_o), 0);
    chk("mid_rst_ack", 32'(ack_o), 0);
    chk("mid_rst_start", 32'(ser_start_o), 0);
    chk("mid_rst_idle", 32'(idle_o), 1);
    rst = 0;
    exp_q.delete();
    m_ptr = NR - 1;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03; words[3] = 8'h04;
    run_batch(4'b1111, 4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    never   = 1;
    err_exp = 1;
    words[0] = 8'h77;
    run_batch(4'b0001, 4'b0000, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("err_sticky", 32'(err_o), 1);
    end
    never = 0;
    rst   = 1;
    @(posedge clk); #1;
    rst     = 0;
    err_exp = 0;
    m_ptr   = NR - 1;
    chk("err_cleared", 32'(err_o), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
